// File: rtl/program_loader_if.sv
// program_loader_if
//   Byte-stream input and program-memory write port of the program loader.
//   master : stream source / memory side (drives byte_valid, byte_data)
//   slave  : the loader (drives byte_ready and the memory write port)
// Signals:
//   byte_valid  byte_data valid this cycle
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (transfer = valid & ready)
//   mem_we      program-memory write strobe
//   mem_addr    program-memory write address
//   mem_wdata   program-memory write data
interface program_loader_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 16
);
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// program_loader
//   Fills the CPU program memory from a byte stream and holds the CPU in
//   reset until a load completes cleanly.
//   Stream: LEN_HI, LEN_LO (word count N), then N x (INSTR_HI, INSTR_LO),
//   written big-endian to consecutive addresses starting at 0.
//   Optional: define LOADER_CHECKSUM_EN to require one trailing byte equal
//   to the XOR of every preceding stream byte (length bytes included).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse, begins a load (only when not busy)
//   bus        program_loader_if.slave: byte stream in, memory write out
//   cpu_reset  active-high reset to the CPU core
//   busy       load in progress
//   done       last load completed successfully (sticky)
//   error      last load failed (sticky)
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_LEN_HI  | waiting for word-count high byte
// S_LEN_LO  | waiting for word-count low byte, range check
// S_DATA_HI | waiting for instruction high byte
// S_DATA_LO | waiting for instruction low byte
// S_WRITE   | one-cycle memory write, advance index
// S_CHECK   | waiting for checksum byte (checksum build only)
// S_DONE    | load good, CPU released
// S_ERROR   | load failed, CPU held in reset
module program_loader #(
  parameter int ADDR_W    = 12,
  parameter int INSTR_W   = 16,
  parameter int MAX_WORDS = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  program_loader_if.slave     bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHECK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t             state_q, state_d;
  logic [7:0]         len_hi_q;
  logic [ADDR_W:0]    len_q;
  logic [ADDR_W:0]    idx_q;
  logic [ADDR_W:0]    idx_inc;
  logic [7:0]         hi_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] mem_wdata_q;
  logic               busy_q, done_q, error_q, cpu_reset_q;
  logic [15:0]        len_full;
  logic               xfer;
  logic               start_ok;
  logic               last_word;
  logic               ready;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         cks_q;
`endif

  assign len_full  = {len_hi_q, bus.byte_data};
  assign idx_inc   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (idx_inc == len_q);
  assign xfer      = bus.byte_valid & ready;

  always_comb begin
    ready = 1'b0;
    case (state_q)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: ready = 1'b1;
`endif
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: if (xfer) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_full > MAX_LEN)  state_d = S_ERROR;
          else if (len_full == 16'd0) state_d = S_FINISH;
          else                     state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (xfer) state_d = S_DATA_LO;
      S_DATA_LO: if (xfer) state_d = S_WRITE;
      S_WRITE:   state_d = last_word ? S_FINISH : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) state_d = (bus.byte_data == cks_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the
  // same edge that enters DONE/ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      busy_q      <= !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
      cpu_reset_q <= (state_d != S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hi_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (start_ok) begin
      idx_q      <= '0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        S_LEN_HI:  if (xfer) len_hi_q <= bus.byte_data;
        S_LEN_LO:  if (xfer) len_q <= len_full[ADDR_W:0];
        S_DATA_HI: if (xfer) hi_q <= bus.byte_data;
        S_DATA_LO: if (xfer) mem_wdata_q <= {hi_q, bus.byte_data};
        S_WRITE: begin
          idx_q <= idx_inc;
          // The final write of a full 4096-word image would wrap the
          // address to 0; keep the last written address instead.
          if (!last_word) mem_addr_q <= idx_inc[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         cks_q <= '0;
    else if (start_ok)                  cks_q <= '0;
    else if (xfer && state_q != S_CHECK) cks_q <= cks_q ^ bus.byte_data;
  end
`endif

  assign bus.byte_ready = ready;
  assign bus.mem_we     = (state_q == S_WRITE);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign cpu_reset      = cpu_reset_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic clk;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, error;

  program_loader_if bus ();

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int len;
    int mode;
    bit corrupt;
    bit exp_done;
    bit exp_err;
    int exp_writes;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] stim_q[$];
  logic [27:0] exp_q[$];
  bit         exp_ok;
  logic [27:0] wr_log[$];
  int         ready_during_we;

  // Write monitor: one record per mem_we cycle.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_log.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.byte_ready !== 1'b0) ready_during_we++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: build a stream of the given length with random
  // instructions; expected writes are (index, {hi,lo}) for each word.
  function automatic void make_stream(input int len, input bit corrupt);
    logic [7:0]  hi, lo, x;
    logic [15:0] l16;
    stim_q.delete();
    exp_q.delete();
    l16 = 16'(len);
    stim_q.push_back(l16[15:8]);
    stim_q.push_back(l16[7:0]);
    if (len > 4096) begin
      exp_ok = 1'b0;
      return;
    end
    for (int k = 0; k < len; k++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      stim_q.push_back(hi);
      stim_q.push_back(lo);
      exp_q.push_back({12'(k), hi, lo});
    end
    exp_ok = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (stim_q[j]) x = x ^ stim_q[j];
    if (corrupt) x = x ^ 8'h5A;
    stim_q.push_back(x);
    exp_ok = !corrupt;
`else
    x = 8'h00;
    if (corrupt && x != 8'h00) exp_ok = 1'b0;
`endif
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: valid held high, 1: valid every other cycle, 2: random valid.
  // start_at >= 0 pulses start once when that byte index is being offered.
  task automatic drive(input int mode, input int start_at, input int limit);
    int  i = 0;
    int  cyc = 0;
    bit  v, xfer, pulsed;
    pulsed = 1'b0;
    while (i < limit && cyc < 20000) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.byte_valid = v;
      bus.byte_data  = v ? stim_q[i] : 8'($urandom);
      start = (!pulsed && i == start_at);
      if (start) pulsed = 1'b1;
      xfer = v && (bus.byte_ready === 1'b1);
      @(posedge clk);
      if (xfer) i++;
      cyc++;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start = 1'b0;
    check("stream_consumed", 32'(i), 32'(limit));
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy === 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("finish_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_load(input string name, input int mode, input int start_at,
                          input bit want_done, input int want_writes);
    wr_log.delete();
    ready_during_we = 0;
    do_start();
    drive(mode, start_at, stim_q.size());
    wait_idle();
    check({name, "_done"},      {31'd0, done},      {31'd0, want_done});
    check({name, "_error"},     {31'd0, error},     {31'd0, !want_done});
    check({name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, !want_done});
    check({name, "_nwrites"},   32'(wr_log.size()), 32'(want_writes));
    check({name, "_ready_in_write"}, 32'(ready_during_we), 32'd0);
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      check({name, "_write"}, {4'd0, wr_log[k]}, {4'd0, exp_q[k]});
  endtask

  task automatic fixed_stream();
    logic [7:0] x;
    stim_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    foreach (stim_q[j]) x = x ^ stim_q[j];
    stim_q.push_back(x);
`else
    x = 8'h00;
`endif
    exp_q = '{{12'h000, 16'h1234}, {12'h001, 16'hABCD}};
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    check("rst_mem_addr",   {20'd0, bus.mem_addr},   32'd0);
    check("rst_mem_wdata",  {16'd0, bus.mem_wdata},  32'd0);
    check("rst_cpu_reset",  {31'd0, cpu_reset},      32'd1);
    check("rst_busy",       {31'd0, busy},           32'd0);
    check("rst_done",       {31'd0, done},           32'd0);
    check("rst_error",      {31'd0, error},          32'd0);

    // Released, no start: valid is offered but never accepted
    reset = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, bus.byte_ready}, 32'd0);
    end
    bus.byte_valid = 1'b0;

    // Fixed stream, valid held; a start pulse mid-load must be ignored
    fixed_stream();
    run_load("fixed_held", 0, 3, 1'b1, 2);
    check("fixed_busy", {31'd0, busy}, 32'd0);

    // Fixed stream, valid toggling
    fixed_stream();
    run_load("fixed_toggle", 1, -1, 1'b1, 2);

    // Table of vectors
    vecs.push_back('{len: 3,      mode: 0, corrupt: 0, exp_done: 1, exp_err: 0, exp_writes: 3});
    vecs.push_back('{len: 0,      mode: 0, corrupt: 0, exp_done: 1, exp_err: 0, exp_writes: 0});
    vecs.push_back('{len: 'h1001, mode: 0, corrupt: 0, exp_done: 0, exp_err: 1, exp_writes: 0});
    vecs.push_back('{len: 'h1000, mode: 0, corrupt: 0, exp_done: 1, exp_err: 0, exp_writes: 4096});
    vecs.push_back('{len: 1,      mode: 2, corrupt: 0, exp_done: 1, exp_err: 0, exp_writes: 1});
    vecs.push_back('{len: 5,      mode: 1, corrupt: 0, exp_done: 1, exp_err: 0, exp_writes: 5});
    vecs.push_back('{len: 'hFFFF, mode: 2, corrupt: 0, exp_done: 0, exp_err: 1, exp_writes: 0});
`ifdef LOADER_CHECKSUM_EN
    vecs.push_back('{len: 3,      mode: 0, corrupt: 1, exp_done: 0, exp_err: 1, exp_writes: 3});
    vecs.push_back('{len: 0,      mode: 2, corrupt: 1, exp_done: 0, exp_err: 1, exp_writes: 0});
`endif
    foreach (vecs[n]) begin
      make_stream(vecs[n].len, vecs[n].corrupt);
      run_load($sformatf("vec%0d", n), vecs[n].mode, -1, vecs[n].exp_done, vecs[n].exp_writes);
      check($sformatf("vec%0d_err_tbl", n), {31'd0, error}, {31'd0, vecs[n].exp_err});
      if (vecs[n].exp_writes == 4096 && wr_log.size() == 4096)
        check("last_addr", {20'd0, wr_log[4095][27:16]}, 32'hFFF);
    end

    // Randomized loads checked against the reference
    for (int r = 0; r < 8; r++) begin
      int  len;
      int  mode;
      bit  cor;
      len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4097, 65535))
                                         : int'($urandom_range(0, 12));
      mode = int'($urandom_range(0, 2));
      cor  = 1'($urandom_range(0, 3) == 0);
      make_stream(len, cor);
      run_load($sformatf("rnd%0d", r), mode, -1, exp_ok, exp_q.size());
    end

    // Reset after the first instruction byte aborts at once
    fixed_stream();
    do_start();
    drive(0, -1, 3);
    reset = 1'b0;
    #1;
    check("abort_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("abort_mem_we",     {31'd0, bus.mem_we},     32'd0);
    check("abort_mem_addr",   {20'd0, bus.mem_addr},   32'd0);
    check("abort_mem_wdata",  {16'd0, bus.mem_wdata},  32'd0);
    check("abort_cpu_reset",  {31'd0, cpu_reset},      32'd1);
    check("abort_busy",       {31'd0, busy},           32'd0);
    check("abort_done",       {31'd0, done},           32'd0);
    check("abort_error",      {31'd0, error},          32'd0);
    @(negedge clk);
    reset = 1'b1;
    fixed_stream();
    run_load("after_abort", 0, -1, 1'b1, 2);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: 00 01 FF 00, correct byte is FE, 00 sent
    stim_q = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h00};
    exp_q  = '{{12'h000, 16'hFF00}};
    run_load("cks_bad", 0, 2, 1'b0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
